// File: rtl/seven_segment_scan_ctrl_if.sv
// rtl/seven_segment_scan_ctrl_if.sv - button inputs and display outputs of the scan controller
interface seven_segment_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                inc_btn;
    logic                dec_btn;
    logic                speed_btn;
    logic [6:0]          segment_bits;
    logic [DIGITS-1:0]   grounds;
    logic [4*DIGITS-1:0] value;
    logic [1:0]          scan_mode;

    modport master (
        output inc_btn, dec_btn, speed_btn,
        input  segment_bits, grounds, value, scan_mode
    );

    modport slave (
        input  inc_btn, dec_btn, speed_btn,
        output segment_bits, grounds, value, scan_mode
    );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// rtl/seven_segment_scan_ctrl.sv - debounced hex up/down counter driving a scanned seven-segment display
module seven_segment_scan_ctrl #(
    parameter int                  DIGITS          = 4,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter int                  SHIFT_SLOW      = 25,
    parameter int                  SHIFT_MED       = 19,
    parameter int                  SHIFT_FAST      = 15,
    parameter logic [4*DIGITS-1:0] RESET_VALUE     = '0,
    parameter bit                  LZ_BLANK        = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    seven_segment_scan_ctrl_if.slave bus
);
    localparam int VW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0]         DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]         C_ONE   = 1;
    localparam logic [VW-1:0]         V_ONE   = 1;
    localparam logic [SHIFT_SLOW-1:0] P_ONE   = 1;
    localparam logic [IW-1:0]         I_ONE   = 1;
    localparam logic [IW-1:0]         I_LAST  = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0]     G_ONE   = 1;

    typedef enum logic [1:0] {
        MODE_SLOW = 2'd0,
        MODE_MED  = 2'd1,
        MODE_FAST = 2'd2
    } mode_t;

    logic [2:0]            raw, sync1, sync2, acc, acc_q, press;
    logic [CW-1:0]         db_cnt [3];
    logic [VW-1:0]         value_q;
    mode_t                 mode;
    logic [SHIFT_SLOW-1:0] presc;
    logic                  tick;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         upper;
    logic [6:0]            seg_next, seg_q;
    logic [DIGITS-1:0]     grounds_q;

    assign raw   = {bus.speed_btn, bus.dec_btn, bus.inc_btn};
    // A press is the rising edge of the accepted level; releases are silent.
    assign press = acc & ~acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_q <= acc;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    acc[i]    <= ~acc[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= RESET_VALUE;
            mode    <= MODE_SLOW;
        end else begin
            if (press[0] && !press[1]) value_q <= value_q + V_ONE;
            else if (press[1] && !press[0]) value_q <= value_q - V_ONE;
            if (press[2]) begin
                case (mode)
                    MODE_SLOW: mode <= MODE_MED;
                    MODE_MED:  mode <= MODE_FAST;
                    // The unused encoding behaves like MODE_SLOW.
                    default:   mode <= (mode == MODE_FAST) ? MODE_SLOW : MODE_MED;
                endcase
            end
        end
    end

    // The prescaler keeps running across mode changes, so ticks can never land on adjacent cycles.
    always_comb begin
        case (mode)
            MODE_MED:  tick = &presc[SHIFT_MED-1:0];
            MODE_FAST: tick = &presc[SHIFT_FAST-1:0];
            default:   tick = &presc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + P_ONE;
            if (tick) idx <= (idx == I_LAST) ? '0 : idx + I_ONE;
        end
    end

    always_comb begin
        upper = value_q >> {idx, 2'b00};
        case (upper[3:0])
            4'h0:    seg_next = 7'b0000001;
            4'h1:    seg_next = 7'b1001111;
            4'h2:    seg_next = 7'b0010010;
            4'h3:    seg_next = 7'b0000110;
            4'h4:    seg_next = 7'b1001100;
            4'h5:    seg_next = 7'b0100100;
            4'h6:    seg_next = 7'b0100000;
            4'h7:    seg_next = 7'b0001111;
            4'h8:    seg_next = 7'b0000000;
            4'h9:    seg_next = 7'b0000100;
            4'hA:    seg_next = 7'b0001000;
            4'hB:    seg_next = 7'b1100000;
            4'hC:    seg_next = 7'b0110001;
            4'hD:    seg_next = 7'b1000010;
            4'hE:    seg_next = 7'b0110000;
            default: seg_next = 7'b0111000;
        endcase
        if (LZ_BLANK && (idx != '0) && (upper == '0)) seg_next = 7'b1111111;
    end

    // Segments and digit enables come from the same register stage so they always switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grounds_q <= G_ONE;
            seg_q     <= 7'b1111111;
        end else begin
            grounds_q <= G_ONE << idx;
            seg_q     <= seg_next;
        end
    end

    assign bus.segment_bits = seg_q;
    assign bus.grounds      = grounds_q;
    assign bus.value        = value_q;
    assign bus.scan_mode    = mode;
endmodule

// File: doc/seven_segment_scan_ctrl.md
# seven_segment_scan_ctrl

Parametrised multi-digit seven-segment display controller with a button-driven hex counter. It is the next generation of the team's 4-digit scan/counter driver and adds a configurable digit count, synchronised and debounced buttons, increment and decrement, a three-step scan-rate selector, and optional leading-zero blanking. It is fully synchronous to one clock: scan timing comes from clock enables, not derived clocks. It sits between the board buttons and the common-ground digit drivers.

## Interface
- DIGITS, 4: number of digits (2..8); value width is 4*DIGITS.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change (>=2).
- SHIFT_SLOW, 25: scan tick period exponent for mode 0 (period 2^SHIFT_SLOW cycles).
- SHIFT_MED, 19: period exponent for mode 1.
- SHIFT_FAST, 15: period exponent for mode 2; requires SHIFT_FAST < SHIFT_MED < SHIFT_SLOW.
- RESET_VALUE, 0: counter value loaded on reset (4*DIGITS bits).
- LZ_BLANK, 0: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- inc_btn  in  1  raw increment button, active-high, asynchronous.
- dec_btn  in  1  raw decrement button.
- speed_btn  in  1  raw scan-rate button.
- segment_bits  out  7  active-low segments, bit6..bit0 = a,b,c,d,e,f,g.
- grounds  out  DIGITS  one-hot digit enable, active-high; bit i = digit i.
- value  out  4*DIGITS  current counter value.
- scan_mode  out  2  current scan mode, 0..2.

## Operation
- **Button path** (per button): 2-FF synchroniser, then debouncer.
  - The debounce counter increments while the synchronised level differs from the accepted level and clears when they match.
  - When the difference has persisted for DEBOUNCE_CYCLES cycles, the accepted level flips.
  - Press event = accepted rises (a 1-cycle pulse). Releases generate nothing.
- **Counter:**
  - Inc event: value+1, modulo 2^(4*DIGITS).
  - Dec event: value-1, modulo 2^(4*DIGITS).
  - Inc and dec events in the same cycle: value unchanged.
- **Scan mode:** a speed event cycles the mode 0→1→2→0. Mode 3 is unreachable; if it ever occurs, decode it as mode 0.
- **Prescaler:**
  - Free-running, SHIFT_SLOW bits wide, never cleared except by reset.
  - Scan tick = 1-cycle pulse when the low SHIFT_x bits of the prescaler are all ones for the current mode.
  - A mode change takes effect on the next cycle. The first new tick arrives within 2^SHIFT_x cycles, with no spurious double tick.
- **Digit index:** increments on each tick and wraps from DIGITS-1 to 0.
- **Registered outputs:**
  - grounds = one-hot(index).
  - segment_bits = hex decode of nibble[index] of value (digit 0 = least significant nibble).
  - Decode table: 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
- **Blanking:** with LZ_BLANK=1, digit i>0 outputs 1111111 when nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- **Reset (asynchronous):**
  - value=RESET_VALUE, index=0, grounds=one-hot bit 0, segment_bits=1111111, scan_mode=0.
  - Prescaler, synchronisers, debounce counters and accepted levels are all cleared to 0.
  - A button held through reset release produces exactly one press event after the normal latency.

## Timing
- **Press latency:** edge 0 is the first clk edge sampling the raw button high.
  - The synchronised level is high after edge 1.
  - The accepted level rises after edge 1+DEBOUNCE_CYCLES.
  - value or scan_mode updates at edge 2+DEBOUNCE_CYCLES.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles is ignored.
- A held button gives exactly one event. A new event requires a debounced release and a debounced re-press.
- **Display latency:** segment_bits and grounds update 1 cycle after a change in index or value. They always change in the same cycle, so a digit never shows a neighbour's pattern.
- Reset mid-debounce or mid-scan discards all pending state. No event is generated from pre-reset activity.

## Test plan
Bench parameters: DIGITS=4, DEBOUNCE_CYCLES=4, SHIFT_SLOW=6, SHIFT_MED=4, SHIFT_FAST=2, RESET_VALUE=16'hFFA7, LZ_BLANK=0 unless noted.
- **Reset and scan:** release reset → value=FFA7, grounds=0001, scan_mode=0. First tick at cycle 63 → grounds=0010 with segment_bits=0001000 ('A'). Next tick (64 cycles later) → grounds=0100, segment_bits=0111000 ('F').
- **Debounce:** hold inc_btn 20 cycles → value=FFA8 exactly once, at edge 6 after first sampling. A 3-cycle inc_btn glitch → value unchanged. Two clean presses of dec_btn → FFA6.
- **Wrap and collision:** value=FFFF plus inc → 0000. Dec at 0000 → FFFF. inc_btn and dec_btn pressed on the same edge → value unchanged.
- **Scan rate:** three speed presses → scan_mode 1, 2, 0; the measured grounds rotation period is 16, 4, then 64 cycles. No double step on any mode change.
- **Blanking:** LZ_BLANK=1, value=0042 → digits 3 and 2 show 1111111, digit 1 shows 1001100, digit 0 shows 0010010. value=0000 → only digit 0 lit, showing 0000001.
- **Reset mid-operation:** assert rst while inc_btn is mid-debounce and grounds=0100 → outputs return to reset values immediately. After release with inc_btn low, no event occurs.
